// File: rtl/instr_mem_sync.sv
// Byte-addressed, big-endian instruction memory with a registered fetch port
// and a byte-enabled program-load port.
module instr_mem_sync #(
    parameter int          ADDR_W      = 32,
    parameter int          DEPTH_BYTES = 512,
    parameter bit          ALIGN_CHECK = 1'b1,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              stall,
    output logic              resp_valid,
    output logic [31:0]       resp_instr,
    output logic              resp_err,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    input  logic [3:0]        ld_be,
    output logic              ld_err,
    output logic [31:0]       fetch_count
);

    localparam int              IDX_W     = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'(DEPTH_BYTES - 4);

    // Handshake: a request is taken on a rising edge when req_valid=1 and
    // stall=0; its result appears on resp_* one cycle later with resp_valid=1.
    // While stall=1 the response registers freeze and the request is dropped.

    logic [7:0]       mem [DEPTH_BYTES];
    logic             fetch_go;
    logic             fetch_range_err;
    logic             fetch_align_err;
    logic             fetch_err;
    logic [31:0]      fetch_word;
    logic             ld_ok;
    logic [IDX_W-1:0] ld_idx;

    always_comb begin
        fetch_go        = req_valid && !stall;
        // Widened compare so addresses near 2^ADDR_W never alias low memory.
        fetch_range_err = {1'b0, req_addr} > LAST_WORD;
        fetch_align_err = ALIGN_CHECK && (req_addr[1:0] != 2'b00);
        fetch_err       = fetch_range_err || fetch_align_err;
        fetch_word      = NOP_WORD;
        if (!fetch_range_err) begin
            for (int i = 0; i < 4; i++) begin
                fetch_word[31-8*i -: 8] = mem[req_addr[IDX_W-1:0] + IDX_W'(i)];
            end
        end
    end

    always_comb begin
        ld_ok  = ld_en && (ld_addr[1:0] == 2'b00) && ({1'b0, ld_addr} <= LAST_WORD);
        ld_idx = ld_addr[IDX_W-1:0];
    end

    // Storage is deliberately outside the reset domain so a loaded program
    // survives reset; reads above see the pre-edge contents.
    always_ff @(posedge clk) begin
        if (ld_ok) begin
            if (ld_be[3]) mem[ld_idx]                <= ld_data[31:24];
            if (ld_be[2]) mem[ld_idx + IDX_W'(1)]    <= ld_data[23:16];
            if (ld_be[1]) mem[ld_idx + IDX_W'(2)]    <= ld_data[15:8];
            if (ld_be[0]) mem[ld_idx + IDX_W'(3)]    <= ld_data[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid  <= 1'b0;
            resp_instr  <= NOP_WORD;
            resp_err    <= 1'b0;
            fetch_count <= 32'd0;
        end else if (!stall) begin
            resp_valid <= req_valid;
            if (fetch_go) begin
                resp_err    <= fetch_err;
                resp_instr  <= fetch_err ? NOP_WORD : fetch_word;
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_err <= 1'b0;
        end else begin
            ld_err <= ld_en && !ld_ok;
        end
    end

endmodule

// File: tb/tb_instr_mem_sync.sv
// Bench for instr_mem_sync: two instances (alignment checked / unchecked)
// share stimulus and are compared against a byte-array reference model.
module tb_instr_mem_sync;

    localparam int DEPTH = 512;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        stall;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic [3:0]  ld_be;

    logic        resp_valid_a, resp_err_a, ld_err_a;
    logic [31:0] resp_instr_a, fetch_count_a;
    logic        resp_valid_u, resp_err_u, ld_err_u;
    logic [31:0] resp_instr_u, fetch_count_u;

    instr_mem_sync #(.ADDR_W(32), .DEPTH_BYTES(DEPTH), .ALIGN_CHECK(1'b1), .NOP_WORD(32'h0)) dut_a (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr), .stall(stall),
        .resp_valid(resp_valid_a), .resp_instr(resp_instr_a), .resp_err(resp_err_a),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_be(ld_be),
        .ld_err(ld_err_a), .fetch_count(fetch_count_a)
    );

    instr_mem_sync #(.ADDR_W(32), .DEPTH_BYTES(DEPTH), .ALIGN_CHECK(1'b0), .NOP_WORD(32'h0)) dut_u (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr), .stall(stall),
        .resp_valid(resp_valid_u), .resp_instr(resp_instr_u), .resp_err(resp_err_u),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_be(ld_be),
        .ld_err(ld_err_u), .fetch_count(fetch_count_u)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model state
    logic [7:0]  ref_mem [DEPTH];
    logic        exp_valid, exp_err_a, exp_err_u, exp_ld_err;
    logic [31:0] exp_instr_a, exp_instr_u, exp_count;
    int          total = 0;
    int          bad   = 0;

    function automatic logic [32:0] ref_fetch(input logic [31:0] a, input bit align);
        if (a > 32'(DEPTH - 4) || (align && a[1:0] != 2'b00))
            return {1'b1, 32'h0};
        return {1'b0, ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
    endfunction

    function automatic logic [31:0] ref_word(input int a);
        return {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_valid_a"}, 32'(resp_valid_a), 32'(exp_valid));
        chk({tag, "_valid_u"}, 32'(resp_valid_u), 32'(exp_valid));
        chk({tag, "_instr_a"}, resp_instr_a, exp_instr_a);
        chk({tag, "_instr_u"}, resp_instr_u, exp_instr_u);
        chk({tag, "_err_a"},   32'(resp_err_a), 32'(exp_err_a));
        chk({tag, "_err_u"},   32'(resp_err_u), 32'(exp_err_u));
        chk({tag, "_count_a"}, fetch_count_a, exp_count);
        chk({tag, "_count_u"}, fetch_count_u, exp_count);
        chk({tag, "_lderr_a"}, 32'(ld_err_a), 32'(exp_ld_err));
        chk({tag, "_lderr_u"}, 32'(ld_err_u), 32'(exp_ld_err));
    endtask

    // driver: apply one cycle of stimulus, update the model, check outputs
    task automatic step(input string tag, input logic rv, input logic [31:0] ra, input logic st,
                        input logic le, input logic [31:0] la, input logic [31:0] ld, input logic [3:0] be);
        logic legal;
        req_valid = rv; req_addr = ra; stall = st;
        ld_en = le; ld_addr = la; ld_data = ld; ld_be = be;
        @(posedge clk);
        #1;
        legal      = le && (la[1:0] == 2'b00) && (la <= 32'(DEPTH - 4));
        exp_ld_err = le && !legal;
        if (!st) begin
            if (rv) begin
                {exp_err_a, exp_instr_a} = ref_fetch(ra, 1'b1);
                {exp_err_u, exp_instr_u} = ref_fetch(ra, 1'b0);
                exp_valid = 1'b1;
                exp_count = exp_count + 32'd1;
            end else begin
                exp_valid = 1'b0;
            end
        end
        if (legal) begin
            for (int i = 0; i < 4; i++)
                if (be[3-i]) ref_mem[la+i] = ld[31-8*i -: 8];
        end
        check_all(tag);
    endtask

    task automatic model_reset();
        exp_valid = 1'b0; exp_err_a = 1'b0; exp_err_u = 1'b0; exp_ld_err = 1'b0;
        exp_instr_a = 32'h0; exp_instr_u = 32'h0; exp_count = 32'd0;
    endtask

    initial begin
        logic [31:0] held_instr;
        logic [31:0] ra, la;
        logic        rv, st, le;
        int          pick;

        req_valid = 1'b0; req_addr = '0; stall = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; ld_be = '0;
        reset = 1'b0;
        model_reset();
        #1 reset = 1'b1;
        #1 check_all("reset");
        @(posedge clk);
        #1 reset = 1'b0;

        // fill the whole array with known random words
        for (int w = 0; w < DEPTH / 4; w++)
            step("fill", 1'b0, 32'h0, 1'b0, 1'b1, 32'(w * 4), $urandom, 4'hF);

        // single load then fetch
        step("tp1_load", 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h8D28000C, 4'hF);
        step("tp1_fetch", 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("tp1_word", resp_instr_a, 32'h8D28000C);

        // back-to-back fetches then a stall
        step("tp2_ld4",  1'b0, 32'h0, 1'b0, 1'b1, 32'd4,  32'h11111111, 4'hF);
        step("tp2_ld8",  1'b0, 32'h0, 1'b0, 1'b1, 32'd8,  32'h22222222, 4'hF);
        step("tp2_ld12", 1'b0, 32'h0, 1'b0, 1'b1, 32'd12, 32'h33333333, 4'hF);
        step("tp2_f0",   1'b1, 32'd0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step("tp2_f4",   1'b1, 32'd4, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("tp2_w4", resp_instr_a, 32'h11111111);
        step("tp2_f8",   1'b1, 32'd8, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("tp2_w8", resp_instr_a, 32'h22222222);
        held_instr = exp_count;
        for (int k = 0; k < 3; k++) begin
            step("tp2_stall", 1'b1, 32'd12, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
            chk("tp2_stall_word", resp_instr_a, 32'h22222222);
            chk("tp2_stall_count", fetch_count_a, held_instr);
        end

        // byte-enabled partial write
        step("tp3_pre",  1'b0, 32'h0, 1'b0, 1'b1, 32'd16, 32'hFFFFFFFF, 4'hF);
        step("tp3_part", 1'b0, 32'h0, 1'b0, 1'b1, 32'd16, 32'h12345678, 4'b1010);
        step("tp3_f16",  1'b1, 32'd16, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("tp3_word", resp_instr_a, 32'h12FF56FF);

        // range / alignment boundaries and a rejected load
        step("tp4_508", 1'b1, 32'd508, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("tp4_508_err", 32'(resp_err_a), 32'd0);
        step("tp4_509", 1'b1, 32'd509, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("tp4_509_err", 32'(resp_err_a), 32'd1);
        chk("tp4_509_instr", resp_instr_a, 32'h0);
        step("tp4_512", 1'b1, 32'd512, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("tp4_512_err", 32'(resp_err_u), 32'd1);
        step("tp4_top", 1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("tp4_top_err", 32'(resp_err_u), 32'd1);
        chk("tp4_top_instr", resp_instr_u, 32'h0);
        step("tp4_badld", 1'b0, 32'h0, 1'b0, 1'b1, 32'd2, 32'hDEADBEEF, 4'hF);
        chk("tp4_ld_err", 32'(ld_err_a), 32'd1);
        step("tp4_pulse", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("tp4_ld_err_clr", 32'(ld_err_a), 32'd0);
        step("tp4_f0", 1'b1, 32'd0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("tp4_mem_kept", resp_instr_a, 32'h8D28000C);

        // same-edge fetch and load, then unaligned fetch
        step("tp5_pre",  1'b0, 32'h0, 1'b0, 1'b1, 32'd20, 32'hAAAAAAAA, 4'hF);
        step("tp5_same", 1'b1, 32'd20, 1'b0, 1'b1, 32'd20, 32'h55555555, 4'hF);
        chk("tp5_old", resp_instr_a, 32'hAAAAAAAA);
        step("tp5_new",  1'b1, 32'd20, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("tp5_new_word", resp_instr_a, 32'h55555555);
        step("tp5_f21",  1'b1, 32'd21, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("tp5_unaligned", resp_instr_u, {24'h555555, ref_mem[24]});
        chk("tp5_aligned_err", 32'(resp_err_a), 32'd1);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            rv   = 1'($urandom_range(0, 1));
            st   = ($urandom_range(0, 3) == 0);
            pick = $urandom_range(0, 4);
            case (pick)
                0, 4:    ra = {23'h0, 7'($urandom_range(0, 127)), 2'b00};
                1:       ra = 32'($urandom_range(0, DEPTH - 1));
                2:       ra = 32'($urandom_range(DEPTH - 3, 2 * DEPTH));
                default: ra = $urandom;
            endcase
            le = ($urandom_range(0, 2) == 0);
            la = {23'h0, 7'($urandom_range(1, 127)), 2'b00};
            if ($urandom_range(0, 3) == 0)
                la = ($urandom_range(0, 1) == 1) ? (la | 32'($urandom_range(1, 3)))
                                                 : 32'($urandom_range(DEPTH - 3, 4 * DEPTH));
            step("rand", rv, ra, st, le, la, $urandom, 4'($urandom_range(0, 15)));
        end

        // asynchronous reset while a response is pending
        step("tp6_f0", 1'b1, 32'd0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("tp6_pending", 32'(resp_valid_a), 32'd1);
        req_valid = 1'b0; ld_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("tp6_async");
        @(posedge clk);
        #1 reset = 1'b0;
        check_all("tp6_hold");
        step("tp6_f0_after", 1'b1, 32'd0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("tp6_mem_persist", resp_instr_a, 32'h8D28000C);
        chk("tp6_count", fetch_count_a, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
